// File: rtl/wrapper_dmac_req_ctrl.sv
// wrapper_dmac_req_ctrl
//   Per-channel DMA request controller sitting between the accelerator
//   wrapper and a PL230-style DMAC. Each channel raises a registered request,
//   waits for the DMAC acknowledge, enforces a post-transfer hold-off, counts
//   completed transfers and keeps sticky done/timeout status.
//
// Ports (all per-channel vectors are NUM_CH wide, bit i = channel i):
//   hclk            clock
//   hresetn         asynchronous active-low reset
//   data_req_active accelerator has data ready / space available
//   data_req_en     software channel enable
//   dma_active      DMAC servicing channel (acknowledge)
//   dma_done        DMAC single-cycle completion pulse
//   status_clr      clears done_flag, timeout_flag, xfer_count of a channel
//   data_req        registered request to DMAC (high only while requesting)
//   done_flag       sticky: dma_done seen
//   timeout_flag    sticky: request timed out
//   xfer_count      completed transfers, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
module wrapper_dmac_req_ctrl #(
  parameter int NUM_CH    = 5,
  parameter int CNT_WIDTH = 8,
  parameter int HOLDOFF   = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                        hclk,
  input  logic                        hresetn,
  input  logic [NUM_CH-1:0]           data_req_active,
  input  logic [NUM_CH-1:0]           data_req_en,
  input  logic [NUM_CH-1:0]           dma_active,
  input  logic [NUM_CH-1:0]           dma_done,
  input  logic [NUM_CH-1:0]           status_clr,
  output logic [NUM_CH-1:0]           data_req,
  output logic [NUM_CH-1:0]           done_flag,
  output logic [NUM_CH-1:0]           timeout_flag,
  output logic [NUM_CH*CNT_WIDTH-1:0] xfer_count
);

  localparam int TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  // The BUSY cycle that observes the dma_active fall is the first hold-off
  // cycle, so HOLD itself lasts HOLDOFF-1 cycles and is skipped for HOLDOFF<=1.
  // This puts the re-request exactly HOLDOFF+1 cycles after the fall.
  localparam int HW        = (HOLDOFF > 2) ? $clog2(HOLDOFF - 1) : 1;
  localparam int HOLD_LAST = (HOLDOFF >= 2) ? HOLDOFF - 2 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                 r_state;
    state_t                 w_next;
    logic [TW-1:0]          r_timer;
    logic [HW-1:0]          r_hold;
    logic                   r_act_d;
    logic                   r_req;
    logic                   r_done;
    logic                   r_to;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   w_go;
    logic                   w_fall;
    logic                   w_to_evt;
    logic                   w_inc;

    always_comb begin
      w_next   = r_state;
      w_to_evt = 1'b0;
      w_inc    = 1'b0;
      w_go     = data_req_active[i] & data_req_en[i];
      w_fall   = r_act_d & ~dma_active[i];
      case (r_state)
        ST_IDLE: if (w_go) w_next = ST_REQ;
        ST_REQ: begin
          if (!data_req_en[i]) begin
            w_next = ST_IDLE;
          end else if (dma_active[i]) begin
            w_next = ST_BUSY;
          end else if ((TIMEOUT != 0) && (r_timer == TW'(TO_LAST))) begin
            w_next   = ST_IDLE;
            w_to_evt = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_fall) begin
            w_inc  = 1'b1;
            w_next = (HOLDOFF >= 2) ? ST_HOLD : ST_IDLE;
          end
        end
        ST_HOLD: if (r_hold == HW'(HOLD_LAST)) w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
        r_state <= ST_IDLE;
        r_timer <= '0;
        r_hold  <= '0;
        r_act_d <= 1'b0;
        r_req   <= 1'b0;
        r_done  <= 1'b0;
        r_to    <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_state <= w_next;
        r_act_d <= dma_active[i];
        r_req   <= (w_next == ST_REQ);
        // Timer is zero whenever not requesting, so every REQ entry starts at 0.
        r_timer <= (r_state == ST_REQ) ? r_timer + 1'b1 : '0;
        r_hold  <= (r_state == ST_HOLD) ? r_hold + 1'b1 : '0;
        // Set events win over a same-cycle clear.
        r_done  <= dma_done[i] | (r_done & ~status_clr[i]);
        r_to    <= w_to_evt | (r_to & ~status_clr[i]);
        if (w_inc) begin
          r_cnt <= status_clr[i] ? CNT_WIDTH'(1) : r_cnt + 1'b1;
        end else if (status_clr[i]) begin
          r_cnt <= '0;
        end
      end
    end

    assign data_req[i]                             = r_req;
    assign done_flag[i]                            = r_done;
    assign timeout_flag[i]                         = r_to;
    assign xfer_count[i*CNT_WIDTH +: CNT_WIDTH]    = r_cnt;
  end

endmodule

// File: tb/tb_wrapper_dmac_req_ctrl.sv
// Testbench for wrapper_dmac_req_ctrl: directed vector table, hand-written
// corner sequences and a randomized run, all checked against a cycle-level
// behavioural model of the channel rules.
module tb_wrapper_dmac_req_ctrl;

  localparam int NCH = 5;
  localparam int CW  = 2;
  localparam int HO  = 2;
  localparam int TO  = 4;
  // Non-requesting cycles spent in hold-off after the cycle that sees the fall.
  localparam int HOLD_LEN = (HO >= 2) ? HO - 1 : 0;

  logic               hclk;
  logic               hresetn;
  logic [NCH-1:0]     data_req_active;
  logic [NCH-1:0]     data_req_en;
  logic [NCH-1:0]     dma_active;
  logic [NCH-1:0]     dma_done;
  logic [NCH-1:0]     status_clr;
  logic [NCH-1:0]     data_req;
  logic [NCH-1:0]     done_flag;
  logic [NCH-1:0]     timeout_flag;
  logic [NCH*CW-1:0]  xfer_count;

  int n_tests = 0;
  int n_fail  = 0;

  wrapper_dmac_req_ctrl #(
    .NUM_CH   (NCH),
    .CNT_WIDTH(CW),
    .HOLDOFF  (HO),
    .TIMEOUT  (TO)
  ) dut (
    .hclk           (hclk),
    .hresetn        (hresetn),
    .data_req_active(data_req_active),
    .data_req_en    (data_req_en),
    .dma_active     (dma_active),
    .dma_done       (dma_done),
    .status_clr     (status_clr),
    .data_req       (data_req),
    .done_flag      (done_flag),
    .timeout_flag   (timeout_flag),
    .xfer_count     (xfer_count)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- behavioural reference model ----------------
  bit m_req   [NCH];
  bit m_xfer  [NCH];
  bit m_prev  [NCH];
  bit m_done  [NCH];
  bit m_to    [NCH];
  int m_age   [NCH];
  int m_quiet [NCH];
  int m_cnt   [NCH];
  bit evt_cnt;
  bit evt_to;

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int c = 0; c < NCH; c++) begin
        m_req[c] = 0; m_xfer[c] = 0; m_prev[c] = 0; m_done[c] = 0;
        m_to[c] = 0; m_age[c] = 0; m_quiet[c] = 0; m_cnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        evt_cnt = 0;
        evt_to  = 0;
        if (m_req[c]) begin
          if (!data_req_en[c]) m_req[c] = 0;
          else if (dma_active[c]) begin
            m_req[c]  = 0;
            m_xfer[c] = 1;
          end else if (TO != 0 && m_age[c] + 1 == TO) begin
            m_req[c] = 0;
            evt_to   = 1;
          end else m_age[c]++;
        end else if (m_xfer[c]) begin
          if (m_prev[c] && !dma_active[c]) begin
            m_xfer[c]  = 0;
            evt_cnt    = 1;
            m_quiet[c] = HOLD_LEN;
          end
        end else if (m_quiet[c] > 0) begin
          m_quiet[c]--;
        end else if (data_req_active[c] && data_req_en[c]) begin
          m_req[c] = 1;
          m_age[c] = 0;
        end
        m_prev[c] = dma_active[c];
        m_done[c] = dma_done[c] | (m_done[c] & !status_clr[c]);
        m_to[c]   = evt_to | (m_to[c] & !status_clr[c]);
        if (evt_cnt) m_cnt[c] = status_clr[c] ? 1 : (m_cnt[c] + 1) % (1 << CW);
        else if (status_clr[c]) m_cnt[c] = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [NCH-1:0]    e_req, e_done, e_to;
    logic [NCH*CW-1:0] e_cnt;
    for (int c = 0; c < NCH; c++) begin
      e_req[c]            = m_req[c];
      e_done[c]           = m_done[c];
      e_to[c]             = m_to[c];
      e_cnt[c*CW +: CW]   = CW'(m_cnt[c]);
    end
    chk("model_data_req", 32'(data_req), 32'(e_req));
    chk("model_done_flag", 32'(done_flag), 32'(e_done));
    chk("model_timeout_flag", 32'(timeout_flag), 32'(e_to));
    chk("model_xfer_count", 32'(xfer_count), 32'(e_cnt));
  endtask

  task automatic drive(input logic [NCH-1:0] dra, input logic [NCH-1:0] en,
                       input logic [NCH-1:0] act, input logic [NCH-1:0] dn,
                       input logic [NCH-1:0] clr);
    data_req_active = dra;
    data_req_en     = en;
    dma_active      = act;
    dma_done        = dn;
    status_clr      = clr;
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
    model_check();
  endtask

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return xfer_count[ch*CW +: CW];
  endfunction

  task automatic do_reset();
    hresetn = 1'b0;
    drive('0, '0, '0, '0, '0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    chk("reset_data_req", 32'(data_req), 32'd0);
    chk("reset_done", 32'(done_flag), 32'd0);
    chk("reset_timeout", 32'(timeout_flag), 32'd0);
    chk("reset_count", 32'(xfer_count), 32'd0);
  endtask

  task automatic xfer(input int ch, input bit clr_on_fall);
    logic [NCH-1:0] b;
    b = NCH'(1) << ch;
    drive(b, b, '0, '0, '0);
    tick();                               // REQ
    drive(b, b, b, '0, '0);
    tick();                               // BUSY
    drive('0, b, '0, '0, clr_on_fall ? b : '0);
    tick();                               // fall seen -> count
    drive('0, b, '0, '0, '0);
    tick();
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NCH-1:0] dra;
    logic [NCH-1:0] en;
    logic [NCH-1:0] act;
    logic [NCH-1:0] exp_req;
    logic [NCH-1:0] exp_to;
    logic [CW-1:0]  exp_cnt0;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ch0: handshake with dma_active at cycles 3-5; ch2: timeout with no ack.
    tbl[0]  = '{5'b00101, 5'b00101, 5'b00000, 5'b00000, 5'b00000, 2'd0};
    tbl[1]  = '{5'b00101, 5'b00101, 5'b00000, 5'b00101, 5'b00000, 2'd0};
    tbl[2]  = '{5'b00101, 5'b00101, 5'b00000, 5'b00101, 5'b00000, 2'd0};
    tbl[3]  = '{5'b00101, 5'b00101, 5'b00001, 5'b00101, 5'b00000, 2'd0};
    tbl[4]  = '{5'b00101, 5'b00101, 5'b00001, 5'b00100, 5'b00000, 2'd0};
    tbl[5]  = '{5'b00101, 5'b00101, 5'b00001, 5'b00000, 5'b00100, 2'd0};
    tbl[6]  = '{5'b00101, 5'b00101, 5'b00000, 5'b00100, 5'b00100, 2'd0};
    tbl[7]  = '{5'b00101, 5'b00101, 5'b00000, 5'b00100, 5'b00100, 2'd1};
    tbl[8]  = '{5'b00101, 5'b00101, 5'b00000, 5'b00100, 5'b00100, 2'd1};
    tbl[9]  = '{5'b00101, 5'b00101, 5'b00000, 5'b00101, 5'b00100, 2'd1};
    tbl[10] = '{5'b00101, 5'b00101, 5'b00000, 5'b00001, 5'b00100, 2'd1};

    hresetn = 1'b0;
    drive('0, '0, '0, '0, '0);
    do_reset();
    for (int r = 0; r < 11; r++) begin
      drive(tbl[r].dra, tbl[r].en, tbl[r].act, '0, '0);
      chk("tbl_data_req", 32'(data_req), 32'(tbl[r].exp_req));
      chk("tbl_timeout", 32'(timeout_flag), 32'(tbl[r].exp_to));
      chk("tbl_cnt0", 32'(cnt_of(0)), 32'(tbl[r].exp_cnt0));
      tick();
    end

    // Enable withdrawal on ch1: during REQ, then during BUSY.
    do_reset();
    drive(5'b00010, 5'b00010, '0, '0, '0);
    tick();
    chk("wd_req_c1", 32'(data_req), 32'b00010);
    tick();
    chk("wd_req_c2", 32'(data_req), 32'b00010);
    drive(5'b00010, 5'b00000, '0, '0, '0);
    tick();
    chk("wd_req_dropped", 32'(data_req), 32'd0);
    tick();
    chk("wd_no_timeout", 32'(timeout_flag), 32'd0);
    drive(5'b00010, 5'b00010, '0, '0, '0);
    tick();
    chk("wd_req_again", 32'(data_req), 32'b00010);
    drive(5'b00010, 5'b00010, 5'b00010, '0, '0);
    tick();
    chk("wd_busy_req", 32'(data_req), 32'd0);
    drive(5'b00010, 5'b00000, 5'b00010, '0, '0);
    tick();
    drive(5'b00010, 5'b00000, 5'b00000, '0, '0);
    tick();
    chk("wd_busy_count", 32'(cnt_of(1)), 32'd1);
    chk("wd_busy_req_after", 32'(data_req), 32'd0);

    // Sticky done and clear collision on ch3.
    do_reset();
    drive('0, '0, '0, 5'b01000, '0);
    tick();
    chk("done_set", 32'(done_flag), 32'b01000);
    drive('0, '0, '0, 5'b01000, 5'b01000);
    tick();
    chk("done_clr_collide", 32'(done_flag), 32'b01000);
    drive('0, '0, '0, '0, 5'b01000);
    tick();
    chk("done_clr_alone", 32'(done_flag), 32'd0);

    // Counter wrap on ch4 (CNT_WIDTH=2), then clear on a completion cycle.
    do_reset();
    for (int k = 0; k < 5; k++) xfer(4, 1'b0);
    chk("wrap_count", 32'(cnt_of(4)), 32'd1);
    xfer(4, 1'b1);
    chk("clr_on_completion", 32'(cnt_of(4)), 32'd1);

    // Asynchronous reset with channels in REQ and BUSY.
    do_reset();
    drive('1, '1, '0, '0, '0);
    tick();
    drive('1, '1, 5'b00011, 5'b11111, '0);
    tick();
    chk("ar_pre_req", 32'(data_req), 32'b11100);
    chk("ar_pre_done", 32'(done_flag), 32'b11111);
    drive('1, '1, 5'b00011, '0, '0);
    #2;
    hresetn = 1'b0;
    #1;
    chk("ar_req_async", 32'(data_req), 32'd0);
    chk("ar_done_async", 32'(done_flag), 32'd0);
    #2;
    hresetn = 1'b1;
    tick();
    chk("ar_restart_req", 32'(data_req), 32'b11111);
    chk("ar_restart_cnt", 32'(xfer_count), 32'd0);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] dra, en, act, dn, clr;
      for (int c = 0; c < NCH; c++) begin
        dra[c] = ($urandom_range(0, 9) < 7);
        en[c]  = ($urandom_range(0, 19) != 0);
        act[c] = ($urandom_range(0, 9) < 3);
        dn[c]  = ($urandom_range(0, 19) == 0);
        clr[c] = ($urandom_range(0, 19) == 0);
      end
      drive(dra, en, act, dn, clr);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
